// File: rtl/rx_word_packer_if.sv
// Handshake bundle between the demodulator, the packer and the host-side word consumer.
// The packer uses the slave view; the demodulator/host side uses the master view.
interface rx_word_packer_if;
  logic [31:0] In_Data;
  logic        In_Valid;
  logic        In_Ready;
  logic [1:0]  Chunk_Sel;
  logic        Flush;
  logic [31:0] Out_Word;
  logic [5:0]  Out_Bits;
  logic        Out_Last;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [7:0]  Drop_Cnt;

  modport slave (
    input  In_Data, In_Valid, Chunk_Sel, Flush, Out_Ready,
    output In_Ready, Out_Word, Out_Bits, Out_Last, Out_Valid, Drop_Cnt
  );

  modport master (
    output In_Data, In_Valid, Chunk_Sel, Flush, Out_Ready,
    input  In_Ready, Out_Word, Out_Bits, Out_Last, Out_Valid, Drop_Cnt
  );
endinterface

// File: rtl/rx_word_packer.sv
// Packs 2/4/8/16-bit demodulated chunks LSB-first into 32-bit words with a
// single output holding register, flush of partial words and a drop counter.
module rx_word_packer (
  input  logic                Clk,
  input  logic                N_Rst,
  rx_word_packer_if.slave     bus
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    CLOSED  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] acc;
  logic [5:0]  fill;
  logic [5:0]  len_q;
  logic        last_q;

  logic [5:0]  len_dec;
  logic [5:0]  len_cur;
  logic [31:0] chunk;
  logic [31:0] acc_next;
  logic [5:0]  fill_next;
  logic        accept;
  logic        out_free;

  always_comb begin
    len_dec = 6'd2;
    case (bus.Chunk_Sel)
      2'b00: len_dec = 6'd2;
      2'b01: len_dec = 6'd4;
      2'b10: len_dec = 6'd8;
      2'b11: len_dec = 6'd16;
      default: len_dec = 6'd2;
    endcase
  end

  // The chunk length is only sampled at the start of a word; it stays fixed
  // until the word closes so fill always lands exactly on 32.
  assign len_cur   = (state == EMPTY) ? len_dec : len_q;
  assign chunk     = bus.In_Data & ((32'd1 << len_cur) - 32'd1);
  assign acc_next  = acc | (chunk << fill);
  assign fill_next = fill + len_cur;

  assign bus.In_Ready = (state != CLOSED);
  assign accept       = bus.In_Valid & bus.In_Ready;
  assign out_free     = ~bus.Out_Valid | bus.Out_Ready;

  always_ff @(posedge Clk) begin
    if (!N_Rst) begin
      state         <= EMPTY;
      acc           <= '0;
      fill          <= '0;
      len_q         <= 6'd2;
      last_q        <= 1'b0;
      bus.Out_Word  <= '0;
      bus.Out_Bits  <= '0;
      bus.Out_Last  <= 1'b0;
      bus.Out_Valid <= 1'b0;
      bus.Drop_Cnt  <= '0;
    end else begin
      if (bus.In_Valid && !bus.In_Ready && bus.Drop_Cnt != 8'hFF)
        bus.Drop_Cnt <= bus.Drop_Cnt + 8'd1;

      if (bus.Out_Valid && bus.Out_Ready)
        bus.Out_Valid <= 1'b0;

      case (state)
        EMPTY: begin
          if (accept) begin
            acc   <= acc_next;
            fill  <= fill_next;
            len_q <= len_dec;
            if (bus.Flush) begin
              state  <= CLOSED;
              last_q <= 1'b1;
            end else begin
              state  <= FILLING;
            end
          end
        end

        FILLING: begin
          if (accept) begin
            acc  <= acc_next;
            fill <= fill_next;
            if (fill_next == 6'd32 || bus.Flush) begin
              state  <= CLOSED;
              last_q <= bus.Flush;
            end
          end else if (bus.Flush) begin
            state  <= CLOSED;
            last_q <= 1'b1;
          end
        end

        CLOSED: begin
          if (bus.Flush)
            last_q <= 1'b1;
          if (out_free) begin
            // A flush landing on the hand-off cycle still tags the word it belongs to.
            bus.Out_Word  <= acc & ~(32'hFFFF_FFFF << fill);
            bus.Out_Bits  <= fill;
            bus.Out_Last  <= last_q | bus.Flush;
            bus.Out_Valid <= 1'b1;
            acc           <= '0;
            fill          <= '0;
            last_q        <= 1'b0;
            state         <= EMPTY;
          end
        end

        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_word_packer.sv
// Bench for rx_word_packer: directed vector table, hand-written corner
// sequences and randomized traffic against a bit-queue reference model.
module tb_rx_word_packer;

  logic Clk;
  logic N_Rst;
  rx_word_packer_if ifc ();

  rx_word_packer dut (
    .Clk   (Clk),
    .N_Rst (N_Rst),
    .bus   (ifc.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference model: current word as a queue of bits plus one output slot.
  bit          m_bits[$];
  int          m_len;
  bit          m_closed;
  bit          m_last;
  bit          m_ov;
  logic [31:0] m_word;
  int          m_nbits;
  bit          m_olast;
  int          m_drop;

  function automatic int dec_len(logic [1:0] s);
    return 2 << s;
  endfunction

  task automatic model_step();
    bit rdy, acc, free;
    if (!N_Rst) begin
      m_bits.delete();
      m_len = 2; m_closed = 0; m_last = 0; m_ov = 0;
      m_word = 0; m_nbits = 0; m_olast = 0; m_drop = 0;
      return;
    end
    rdy  = !m_closed;
    acc  = ifc.In_Valid && rdy;
    free = !m_ov || ifc.Out_Ready;
    if (ifc.In_Valid && !rdy && m_drop < 255) m_drop++;
    if (m_ov && ifc.Out_Ready) m_ov = 0;
    if (m_closed) begin
      if (ifc.Flush) m_last = 1;
      if (free) begin
        m_word = 0;
        foreach (m_bits[i]) m_word[i] = m_bits[i];
        m_nbits = m_bits.size();
        m_olast = m_last;
        m_ov = 1;
        m_bits.delete();
        m_closed = 0;
        m_last = 0;
      end
    end else begin
      if (acc) begin
        if (m_bits.size() == 0) m_len = dec_len(ifc.Chunk_Sel);
        for (int i = 0; i < m_len; i++) m_bits.push_back(ifc.In_Data[i]);
      end
      if (m_bits.size() == 32 || (ifc.Flush && m_bits.size() > 0)) begin
        m_closed = 1;
        m_last = ifc.Flush;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: step the model with the inputs now applied, clock, compare.
  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    chk("mdl_in_ready", {31'd0, ifc.In_Ready}, {31'd0, !m_closed});
    chk("mdl_out_valid", {31'd0, ifc.Out_Valid}, {31'd0, m_ov});
    chk("mdl_drop_cnt", {24'd0, ifc.Drop_Cnt}, m_drop);
    if (m_ov) begin
      chk("mdl_out_word", ifc.Out_Word, m_word);
      chk("mdl_out_bits", {26'd0, ifc.Out_Bits}, m_nbits);
      chk("mdl_out_last", {31'd0, ifc.Out_Last}, {31'd0, m_olast});
    end
  endtask

  task automatic drive(bit v, logic [31:0] d, logic [1:0] sel, bit fl, bit ordy);
    ifc.In_Valid  = v;
    ifc.In_Data   = d;
    ifc.Chunk_Sel = sel;
    ifc.Flush     = fl;
    ifc.Out_Ready = ordy;
  endtask

  task automatic do_reset(int n);
    N_Rst = 0;
    drive(0, 0, 2'b00, 0, 0);
    for (int i = 0; i < n; i++) tick();
    N_Rst = 1;
  endtask

  typedef struct {
    bit          v;
    logic [31:0] d;
    logic [1:0]  sel;
    bit          fl;
    bit          ordy;
    bit          e_rdy;
    bit          e_ov;
    logic [31:0] e_word;
    logic [5:0]  e_bits;
    bit          e_last;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(bit v, logic [31:0] d, logic [1:0] sel, bit fl, bit ordy,
                              bit e_rdy, bit e_ov, logic [31:0] e_word, logic [5:0] e_bits,
                              bit e_last);
    vec_t r;
    r.v = v; r.d = d; r.sel = sel; r.fl = fl; r.ordy = ordy;
    r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_word = e_word; r.e_bits = e_bits; r.e_last = e_last;
    return r;
  endfunction

  initial begin
    tbl[0]  = mk(0, 32'h0,         2'b11, 1, 1, 1, 0, 0, 0, 0);  // flush while empty
    tbl[1]  = mk(0, 32'h0,         2'b11, 0, 1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1, 32'h1234_BEEF, 2'b11, 0, 1, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 32'hFFFF_DEAD, 2'b11, 0, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 32'h0,         2'b11, 0, 1, 1, 1, 32'hDEAD_BEEF, 6'd32, 0);
    tbl[5]  = mk(0, 32'h0,         2'b11, 0, 1, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 32'hFFFF_FFA5, 2'b10, 0, 1, 1, 0, 0, 0, 0);
    tbl[7]  = mk(1, 32'h0000_993C, 2'b10, 0, 1, 1, 0, 0, 0, 0);
    tbl[8]  = mk(1, 32'h0000_007E, 2'b10, 1, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 32'h0,         2'b10, 0, 1, 1, 1, 32'h007E_3CA5, 6'd24, 1);
    tbl[10] = mk(0, 32'h0,         2'b10, 0, 1, 1, 0, 0, 0, 0);
  end

  initial begin
    N_Rst = 1;
    drive(0, 0, 2'b00, 0, 0);
    #2;

    // Reset and idle state
    do_reset(2);
    chk("rst_out_word", ifc.Out_Word, 32'h0);
    chk("rst_out_bits", {26'd0, ifc.Out_Bits}, 32'd0);
    chk("rst_out_last", {31'd0, ifc.Out_Last}, 32'd0);
    chk("rst_out_valid", {31'd0, ifc.Out_Valid}, 32'd0);
    chk("rst_drop", {24'd0, ifc.Drop_Cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, ifc.In_Ready}, 32'd1);

    // Vector table: empty flush, 16-bit word, flushed 24-bit word
    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].d, tbl[k].sel, tbl[k].fl, tbl[k].ordy);
      tick();
      chk($sformatf("tbl%0d_in_ready", k), {31'd0, ifc.In_Ready}, {31'd0, tbl[k].e_rdy});
      chk($sformatf("tbl%0d_out_valid", k), {31'd0, ifc.Out_Valid}, {31'd0, tbl[k].e_ov});
      if (tbl[k].e_ov) begin
        chk($sformatf("tbl%0d_out_word", k), ifc.Out_Word, tbl[k].e_word);
        chk($sformatf("tbl%0d_out_bits", k), {26'd0, ifc.Out_Bits}, {26'd0, tbl[k].e_bits});
        chk($sformatf("tbl%0d_out_last", k), {31'd0, ifc.Out_Last}, {31'd0, tbl[k].e_last});
      end
    end

    // Sixteen 2-bit chunks; Chunk_Sel moves to 8 bits mid-word and must be ignored
    for (int i = 0; i < 16; i++) begin
      drive(1, 32'hFFFF_FFFD, (i >= 5) ? 2'b10 : 2'b00, 0, 1);
      tick();
    end
    chk("sel2_closed_rdy", {31'd0, ifc.In_Ready}, 32'd0);
    drive(0, 0, 2'b10, 0, 1);
    tick();
    chk("sel2_valid", {31'd0, ifc.Out_Valid}, 32'd1);
    chk("sel2_word", ifc.Out_Word, 32'h5555_5555);
    chk("sel2_bits", {26'd0, ifc.Out_Bits}, 32'd32);
    chk("sel2_last", {31'd0, ifc.Out_Last}, 32'd0);

    // Consumer stall: one word held, one pending, three drops
    do_reset(1);
    drive(1, 32'h1111, 2'b11, 0, 0); tick();
    drive(1, 32'h2222, 2'b11, 0, 0); tick();
    drive(0, 0, 2'b11, 0, 0); tick();
    chk("stall_w1_valid", {31'd0, ifc.Out_Valid}, 32'd1);
    drive(1, 32'h4444, 2'b11, 0, 0); tick();
    drive(1, 32'h3333, 2'b11, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h9999, 2'b11, 0, 0); tick();
    end
    chk("stall_drop", {24'd0, ifc.Drop_Cnt}, 32'd3);
    chk("stall_word_hold", ifc.Out_Word, 32'h2222_1111);
    chk("stall_rdy", {31'd0, ifc.In_Ready}, 32'd0);
    drive(0, 0, 2'b11, 0, 1); tick();
    chk("stall_w2_valid", {31'd0, ifc.Out_Valid}, 32'd1);
    chk("stall_w2_word", ifc.Out_Word, 32'h3333_4444);
    chk("stall_rdy_back", {31'd0, ifc.In_Ready}, 32'd1);
    tick();
    chk("stall_drained", {31'd0, ifc.Out_Valid}, 32'd0);

    // Reset with a held word and a partial word in flight
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h10 + i, 2'b10, 0, 0); tick();
      if (i == 3) begin drive(0, 0, 2'b10, 0, 0); tick(); end
    end
    chk("pre_rst_valid", {31'd0, ifc.Out_Valid}, 32'd1);
    do_reset(1);
    chk("mid_rst_valid", {31'd0, ifc.Out_Valid}, 32'd0);
    chk("mid_rst_word", ifc.Out_Word, 32'h0);
    chk("mid_rst_rdy", {31'd0, ifc.In_Ready}, 32'd1);
    drive(1, 32'h1234, 2'b11, 0, 1); tick();
    drive(1, 32'h5678, 2'b11, 0, 1); tick();
    drive(0, 0, 2'b11, 0, 1); tick();
    chk("post_rst_word", ifc.Out_Word, 32'h5678_1234);
    chk("post_rst_valid", {31'd0, ifc.Out_Valid}, 32'd1);
    tick();
    chk("post_rst_single", {31'd0, ifc.Out_Valid}, 32'd0);

    // Drop counter saturation under a permanently stalled consumer
    do_reset(1);
    for (int i = 0; i < 270; i++) begin
      drive(1, $urandom, 2'b11, 0, 0); tick();
    end
    chk("drop_sat", {24'd0, ifc.Drop_Cnt}, 32'd255);

    // Randomized traffic against the model
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 4), $urandom, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_word_packer.md
# rx_word_packer

Receive-side output packer sitting directly downstream of the DCSK demodulator datapath. Accepts demodulated chunks of 2, 4, 8 or 16 bits (one chunk per demodulated frame, width set by the spread-factor select) and packs them LSB-first into 32-bit words. Words are delivered to the host/bus side over a valid/ready handshake. Supports a flush for partial words and counts chunks dropped while stalled, since the demodulator cannot be back-pressured.

## Interface
- No parameters; all widths fixed.
- Clk  in  1  system clock, all logic on rising edge.
- N_Rst  in  1  synchronous, active-low reset.
- In_Data  in  32  demodulated frame; valid bits are In_Data[L-1:0], upper bits ignored.
- In_Valid  in  1  one-cycle strobe: In_Data holds a new chunk.
- In_Ready  out  1  packer can accept a chunk this cycle.
- Chunk_Sel  in  2  chunk length L: 00→2, 01→4, 10→8, 11→16.
- Flush  in  1  one-cycle strobe: close the current partial word.
- Out_Word  out  32  packed word; first-received bit at bit 0.
- Out_Bits  out  6  number of valid bits in Out_Word (1..32).
- Out_Last  out  1  word was closed by Flush.
- Out_Valid  out  1  Out_Word/Out_Bits/Out_Last valid.
- Out_Ready  in  1  consumer accepts the word when high with Out_Valid.
- Drop_Cnt  out  8  saturating count of chunks lost (In_Valid while In_Ready=0).

## Operation
- Storage: accumulator Acc[31:0], fill counter Fill[5:0] (0..32), latched length Len_Q, flag Last_Q; one output holding register (Out_Word, Out_Bits, Out_Last, Out_Valid).
- FSM states: EMPTY (Fill=0), FILLING (0<Fill<32, no close pending), CLOSED (word complete: Fill=32, or Flush seen with Fill>0).
- In_Ready = 1 in EMPTY and FILLING, 0 in CLOSED. Combinational from state only.
- Accept = In_Valid & In_Ready. On accept: Acc[Fill +: Len] ← In_Data[Len-1:0]; Fill ← Fill+Len.
- Len used = Chunk_Sel decoded in EMPTY (also latched into Len_Q); Len_Q in FILLING. Chunk_Sel changes while FILLING ignored until the word closes. Since L divides 32 and is fixed per word, Fill never exceeds 32.
- EMPTY→FILLING on accept. FILLING→CLOSED when accept makes Fill=32, or on Flush. EMPTY + Flush (no accept): ignored, no word emitted.
- Accept and Flush in same cycle: chunk packed first, then word closes with Last_Q=1 (including when that chunk fills to 32).
- Flush while CLOSED: sets Last_Q=1 on the pending word.
- CLOSED→EMPTY transfer: when output register free (Out_Valid=0 or Out_Ready=1 this cycle), load Out_Word←Acc with bits [31:Fill] zeroed, Out_Bits←Fill (32 encoded as 6'd32), Out_Last←Last_Q, Out_Valid←1; clear Acc, Fill, Last_Q.
- Output register: Out_Valid drops after Out_Ready handshake unless reloaded same edge. Contents stable while Out_Valid=1 and Out_Ready=0.
- Drop: In_Valid & ~In_Ready → Drop_Cnt+1, saturating at 255; dropped chunk not stored. Cleared only by reset.
- Flush arriving while Out_Valid=1 and stalled just waits in CLOSED (no second buffer).

## Timing
- Reset (N_Rst=0 at edge): state EMPTY, Fill=0, Acc=0, Len_Q=2, Last_Q=0, Out_Word=0, Out_Bits=0, Out_Last=0, Out_Valid=0, Drop_Cnt=0; In_Ready=1 after the reset edge. Reset mid-word or mid-handshake discards all data, no output.
- Latency: chunk completing a word at edge N → state CLOSED after N; Out_Valid=1 after edge N+1 if output register free.
- In_Ready=0 for at least one cycle per word (the CLOSED cycle); longer while consumer stalls.
- Peak throughput with Out_Ready=1: 16-bit chunks → one word per 3 cycles; demodulator frame spacing (≥ 2·spread factor cycles per bit) guarantees no drops when consumer keeps Out_Ready high.

## Test plan
- Reset/idle: N_Rst low 2 cycles → all outputs 0, In_Ready=1; Flush with Fill=0 → no Out_Valid.
- Chunk_Sel=11, chunks 0xBEEF then 0xDEAD, Out_Ready=1 → one word 0xDEADBEEF, Out_Bits=32, Out_Last=0, Out_Valid 1 cycle after second accept.
- Chunk_Sel=00, sixteen chunks of 2'b01 → word 0x55555555, Out_Bits=32; Chunk_Sel toggled to 10 mid-word has no effect.
- Chunk_Sel=10, chunks 0xA5, 0x3C, then Flush in same cycle as third chunk 0x7E → word 0x007E3CA5, Out_Bits=24, Out_Last=1.
- Out_Ready held 0: complete word 1 (held), complete word 2 (CLOSED), 3 more In_Valid pulses → Drop_Cnt=3, Out_Word stable; release Out_Ready → both words delivered in order, In_Ready returns to 1.
- Reset asserted with Fill=8 and Out_Valid=1 → everything cleared next edge; following 0x1234/0x5678 (Chunk_Sel=11) produces 0x56781234 only.
